keypad_scanner: RTL and testbench

Matrix-keypad input scanner for the board top level: the input-side counterpart of the multiplexed seven-segment display. It drives the columns of a 4x4 keypad one at a time, reads the rows, and debounces the result using the display's 1 ms enable strobe. It delivers a 4-bit key code with a one-cycle valid pulse, plus a held flag, for counters or other user logic to consume.

---
 rtl/keypad_pkg.sv | 24 ++
 rtl/keypad_scanner_if.sv | 12 +
 rtl/keypad_sync.sv | 32 +++
 rtl/keypad_scanner.sv | 161 ++++++++++++++++
 tb/tb_keypad_scanner.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared types, sizes and row priority helper for the keypad scanner
package keypad_pkg;

    localparam int NCOL = 4;
    localparam int NROW = 4;

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEB,
        ST_HELD,
        ST_REL
    } state_t;

    // Index of the lowest-numbered asserted bit; callers guarantee a non-zero mask.
    function automatic logic [1:0] row_prio(input logic [3:0] low_mask);
        logic [1:0] idx;
        if (low_mask[0])      idx = 2'd0;
        else if (low_mask[1]) idx = 2'd1;
        else if (low_mask[2]) idx = 2'd2;
        else                  idx = 2'd3;
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// rtl/keypad_scanner_if.sv - key code / valid pulse / held flag bundle between scanner and user logic
interface keypad_scanner_if;
    import keypad_pkg::*;

    logic [$clog2(NROW*NCOL)-1:0] key;
    logic                         key_vld;
    logic                         held;

    modport master (output key, output key_vld, output held);
    modport slave  (input  key, input  key_vld, input  held);

endinterface

// File: rtl/keypad_sync.sv
// rtl/keypad_sync.sv - N-bit two-flop synchronizer with per-bit reset value
module keypad_sync #(
    parameter int           N       = 4,
    parameter logic [N-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    logic [N-1:0] meta_q, meta_d;
    logic [N-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scan + debounce; KEYPAD_REPEAT_EN adds hold auto-repeat
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int DEB_MS    = 8,
    parameter int REPEAT_MS = 250
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ce_1ms,
    input  logic [NROW-1:0]         row,
    output logic [NCOL-1:0]         col,
    keypad_scanner_if.master        kp
);

    localparam int             CW       = $clog2(DEB_MS + 1);
    localparam logic [CW-1:0]  DEB_LAST = CW'(DEB_MS);

    if (DEB_MS < 2 || DEB_MS > 255 || REPEAT_MS < 1) begin : g_bad_param
        $error("keypad_scanner: DEB_MS must be 2..255 and REPEAT_MS at least 1");
    end

    state_t         state_q, state_d;
    logic [1:0]     col_idx_q, col_idx_d;
    logic [1:0]     row_idx_q, row_idx_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [3:0]     key_q, key_d;
    logic           key_vld_q, key_vld_d;
    logic           held_q, held_d;

`ifdef KEYPAD_REPEAT_EN
    localparam int             RW       = $clog2(REPEAT_MS + 1);
    localparam logic [RW-1:0]  REP_LAST = RW'(REPEAT_MS);
    logic [RW-1:0]  rep_q, rep_d;
`endif

    logic [NROW-1:0] row_s;
    logic [CW-1:0]   cnt_inc;
    logic            lat_low;

    keypad_sync #(
        .N       (NROW),
        .RST_VAL (4'hF)
    ) u_row_sync (
        .clk (clk),
        .rst (rst),
        .d   (row),
        .q   (row_s)
    );

    assign cnt_inc = cnt_q + 1'b1;
    // Only the latched row matters once a key is being tracked; other rows are ignored.
    assign lat_low = ~row_s[row_idx_q];

    always_comb begin
        state_d   = state_q;
        col_idx_d = col_idx_q;
        row_idx_d = row_idx_q;
        cnt_d     = cnt_q;
        key_d     = key_q;
        key_vld_d = 1'b0;
        held_d    = held_q;
`ifdef KEYPAD_REPEAT_EN
        rep_d     = rep_q;
`endif
        if (ce_1ms) begin
            unique case (state_q)
                ST_SCAN: begin
                    if (&row_s) begin
                        col_idx_d = col_idx_q + 2'd1;
                    end else begin
                        row_idx_d = row_prio(~row_s);
                        cnt_d     = CW'(1);
                        state_d   = ST_DEB;
                    end
                end
                ST_DEB: begin
                    if (!lat_low) begin
                        state_d   = ST_SCAN;
                        col_idx_d = col_idx_q + 2'd1;
                    end else if (cnt_inc == DEB_LAST) begin
                        key_d     = {row_idx_q, col_idx_q};
                        key_vld_d = 1'b1;
                        held_d    = 1'b1;
                        state_d   = ST_HELD;
`ifdef KEYPAD_REPEAT_EN
                        rep_d     = '0;
`endif
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                ST_HELD: begin
                    if (!lat_low) begin
                        cnt_d   = CW'(1);
                        state_d = ST_REL;
`ifdef KEYPAD_REPEAT_EN
                        rep_d   = '0;
`endif
                    end
`ifdef KEYPAD_REPEAT_EN
                    else if (rep_q + 1'b1 == REP_LAST) begin
                        rep_d     = '0;
                        key_vld_d = 1'b1;
                    end else begin
                        rep_d = rep_q + 1'b1;
                    end
`endif
                end
                ST_REL: begin
                    // A low tick here is release bounce, not a fresh press.
                    if (lat_low) begin
                        state_d = ST_HELD;
`ifdef KEYPAD_REPEAT_EN
                        rep_d   = '0;
`endif
                    end else if (cnt_inc == DEB_LAST) begin
                        held_d    = 1'b0;
                        state_d   = ST_SCAN;
                        col_idx_d = col_idx_q + 2'd1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: state_d = ST_SCAN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_SCAN;
            col_idx_q <= 2'd0;
            row_idx_q <= 2'd0;
            cnt_q     <= '0;
            key_q     <= 4'd0;
            key_vld_q <= 1'b0;
            held_q    <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            col_idx_q <= col_idx_d;
            row_idx_q <= row_idx_d;
            cnt_q     <= cnt_d;
            key_q     <= key_d;
            key_vld_q <= key_vld_d;
            held_q    <= held_d;
`ifdef KEYPAD_REPEAT_EN
            rep_q     <= rep_d;
`endif
        end
    end

    assign col        = ~(4'b0001 << col_idx_q);
    assign kp.key     = key_q;
    assign kp.key_vld = key_vld_q;
    assign kp.held    = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - directed table-driven bench for keypad_scanner with a 4x4 key matrix model
module tb_keypad_scanner;

    localparam int DEB = 4;
    localparam int REP = 5;
`ifdef KEYPAD_REPEAT_EN
    localparam int EXP_HOLD_PULSES = 4;
`else
    localparam int EXP_HOLD_PULSES = 1;
`endif

    typedef struct {
        logic [15:0] keys;
        int          ticks;
        logic [3:0]  col;
        logic [3:0]  key;
        logic        held;
        int          pulses;
    } step_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce_1ms;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [15:0] pressed;

    int   checks    = 0;
    int   failures  = 0;
    int   pulse_cnt = 0;
    logic prev_vld  = 1'b0;

    step_t steps[$];

    keypad_scanner_if kp_if ();

    keypad_scanner #(
        .DEB_MS    (DEB),
        .REPEAT_MS (REP)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .ce_1ms (ce_1ms),
        .row    (row),
        .col    (col),
        .kp     (kp_if)
    );

    always #5 clk = ~clk;

    // Key (r,c) pulls row r low while column c is driven low.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
    end

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] actual=%0h expected=%0h", name, idx, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (kp_if.key_vld) begin
            pulse_cnt++;
            chk("vld_one_cycle", pulse_cnt, {31'b0, prev_vld}, 32'd0);
        end
        prev_vld = kp_if.key_vld;
    end

    task automatic tick();
        repeat (4) @(negedge clk);
        ce_1ms = 1'b1;
        @(negedge clk);
        ce_1ms = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic void add(input logic [15:0] k, input int n, input logic [3:0] c,
                                input logic [3:0] ky, input logic h, input int p);
        step_t s;
        s.keys = k; s.ticks = n; s.col = c; s.key = ky; s.held = h; s.pulses = p;
        steps.push_back(s);
    endfunction

    initial begin
        int base;

        // idle scan
        add(16'h0000, 1, 4'b1101, 4'd0, 1'b0, 0);
        add(16'h0000, 1, 4'b1011, 4'd0, 1'b0, 0);
        add(16'h0000, 1, 4'b0111, 4'd0, 1'b0, 0);
        add(16'h0000, 1, 4'b1110, 4'd0, 1'b0, 0);
        // key 6 (row1,col2): two scan ticks, then four debounce ticks
        add(16'h0040, 2, 4'b1011, 4'd0, 1'b0, 0);
        add(16'h0040, 3, 4'b1011, 4'd0, 1'b0, 0);
        add(16'h0040, 1, 4'b1011, 4'd6, 1'b1, 1);
        add(16'h0040, 3, 4'b1011, 4'd6, 1'b1, 0);
        add(16'h0000, 3, 4'b1011, 4'd6, 1'b1, 0);
        add(16'h0000, 1, 4'b0111, 4'd6, 1'b0, 0);
        // key 7 bounce: two low ticks rejected, then a stable press
        add(16'h0080, 2, 4'b0111, 4'd6, 1'b0, 0);
        add(16'h0000, 1, 4'b1110, 4'd6, 1'b0, 0);
        add(16'h0080, 3, 4'b0111, 4'd6, 1'b0, 0);
        add(16'h0080, 3, 4'b0111, 4'd6, 1'b0, 0);
        add(16'h0080, 1, 4'b0111, 4'd7, 1'b1, 1);
        add(16'h0000, 4, 4'b1110, 4'd7, 1'b0, 0);
        // rows 1 and 3 on column 0, then key 10 pressed while held
        add(16'h1010, 3, 4'b1110, 4'd7, 1'b0, 0);
        add(16'h1010, 1, 4'b1110, 4'd4, 1'b1, 1);
        add(16'h1410, 4, 4'b1110, 4'd4, 1'b1, 0);
        add(16'h0400, 3, 4'b1110, 4'd4, 1'b1, 0);
        add(16'h0400, 1, 4'b1101, 4'd4, 1'b0, 0);
        add(16'h0400, 1, 4'b1011, 4'd4, 1'b0, 0);
        add(16'h0400, 3, 4'b1011, 4'd4, 1'b0, 0);
        add(16'h0400, 1, 4'b1011, 4'd10, 1'b1, 1);
        add(16'h0000, 4, 4'b0111, 4'd10, 1'b0, 0);

        rst = 1'b1; ce_1ms = 1'b0; pressed = 16'h0;
        repeat (3) @(negedge clk);
        chk("rst_col", 0, {28'b0, col}, 32'hE);
        chk("rst_key", 0, {28'b0, kp_if.key}, 32'h0);
        chk("rst_vld", 0, {31'b0, kp_if.key_vld}, 32'h0);
        chk("rst_held", 0, {31'b0, kp_if.held}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < steps.size(); i++) begin
            pressed = steps[i].keys;
            base = pulse_cnt;
            ticks(steps[i].ticks);
            chk("col", i, {28'b0, col}, {28'b0, steps[i].col});
            chk("key", i, {28'b0, kp_if.key}, {28'b0, steps[i].key});
            chk("held", i, {31'b0, kp_if.held}, {31'b0, steps[i].held});
            chk("pulses", i, pulse_cnt - base, steps[i].pulses);
        end

        // reset in the middle of debounce (cnt=3) on key 3 (row0,col3)
        pressed = 16'h0008;
        base = pulse_cnt;
        ticks(3);
        chk("deb_col", 0, {28'b0, col}, 32'h7);
        chk("deb_held", 0, {31'b0, kp_if.held}, 32'h0);
        rst = 1'b1;
        #1;
        chk("midrst_col", 0, {28'b0, col}, 32'hE);
        chk("midrst_key", 0, {28'b0, kp_if.key}, 32'h0);
        chk("midrst_vld", 0, {31'b0, kp_if.key_vld}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        pressed = 16'h0;
        ticks(4);
        chk("postrst_col", 0, {28'b0, col}, 32'hE);
        chk("postrst_pulses", 0, pulse_cnt - base, 0);

        // long hold on key 8 (row2,col0): auto-repeat only when enabled
        pressed = 16'h0100;
        base = pulse_cnt;
        ticks(4);
        chk("hold_accept_key", 0, {28'b0, kp_if.key}, 32'h8);
        chk("hold_accept_pulses", 0, pulse_cnt - base, 1);
        ticks(17);
        chk("hold_pulses", 0, pulse_cnt - base, EXP_HOLD_PULSES);
        chk("hold_key", 0, {28'b0, kp_if.key}, 32'h8);
        chk("hold_held", 0, {31'b0, kp_if.held}, 32'h1);
        pressed = 16'h0;
        ticks(4);
        chk("hold_rel_held", 0, {31'b0, kp_if.held}, 32'h0);
        chk("hold_rel_col", 0, {28'b0, col}, 32'hD);
        chk("hold_rel_pulses", 0, pulse_cnt - base, EXP_HOLD_PULSES);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
